bbox_scanner: RTL and testbench
===============================

Name: bbox_scanner

Overview:
- Parametrised successor to the fixed 100x100 RGB bounding-box finder.
- Scans a column-major multi-channel image in external read-only memory, one read per cycle.
- Reports the pixel-unit bounding box of all pixels where any channel is at or above a runtime threshold.
- Sits between the frame memory and the downstream crop/centroid logic; supports configurable image size, channel count, data width and memory read latency.

Parameters:
- IMG_W, 100, image width in pixels (x range 0..IMG_W-1)
- IMG_H, 100, image height in pixels (y range 0..IMG_H-1)
- CHANNELS, 3, words per pixel, stored consecutively
- DATA_W, 16, memory word width
- ADDR_W, 24, address width
- COORD_W, 11, coordinate output width; must satisfy 2^COORD_W > max(IMG_W, IMG_H)
- RD_LAT, 1, cycles from addr/rd_en to valid rddata (1..4)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a scan; sampled in IDLE or DONE
- threshold  in  DATA_W  hit threshold; latched on the accepted start
- busy  out  1  high in SCAN and DRAIN
- done  out  1  high in DONE; results valid
- rd_en  out  1  read strobe
- addr  out  ADDR_W  read address
- rddata  in  DATA_W  read data, valid RD_LAT cycles after rd_en
- obj_found  out  1  at least one hit pixel in the last scan
- x_min, x_max, y_min, y_max  out  COORD_W each  bounding box in pixel coordinates

Behaviour:
- Reset is asynchronous and active-low. Reset values: state IDLE, busy 0, done 0, rd_en 0, addr 0, obj_found 0, x_min IMG_W-1, x_max 0, y_min IMG_H-1, y_max 0.
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE -> SCAN on start. On the transition: latch threshold, clear bounds to reset values, clear obj_found.
  - SCAN: rd_en=1 every cycle. Loop order is c innermost, then y, then x. addr = (x*IMG_H + y)*CHANNELS + c. After the last address (IMG_W*IMG_H*CHANNELS-1), go to DRAIN.
  - DRAIN: rd_en=0. Stay exactly RD_LAT cycles, then go to DONE.
  - DONE: done=1 and outputs held. start re-enters SCAN with the same clearing as IDLE->SCAN, and done drops the next cycle.
- start is ignored in SCAN and DRAIN.
- Read pipeline: an RD_LAT-deep delay line carries (valid, x, y, last_channel) alongside each read.
- Per-pixel hit: OR of (rddata >= threshold) over the pixel's CHANNELS words, unsigned compare. Equality counts as a hit.
- Bounds update only on the return of a pixel's last-channel word, and only if that pixel hit:
  - x_min/x_max/y_min/y_max update by min/max
  - obj_found set to 1
- Bound outputs may change during SCAN/DRAIN; they are defined only while done=1.
- Timing: the rd_en burst is exactly IMG_W*IMG_H*CHANNELS consecutive cycles. done rises RD_LAT+1 cycles after the last rd_en cycle.
- Empty image: obj_found=0 and bounds keep their reset values. Downstream must gate on obj_found.
- Single-pixel image (IMG_W=IMG_H=1) must work.
- Reset mid-scan: immediate return to reset values. In-flight read returns are discarded.

Optional Feature:
- Macro: BBOX_PIXEL_COUNT_EN.
- Defined: adds output pixel_count, width $clog2(IMG_W*IMG_H+1).
  - Counts hit pixels; increments on the same event as the bounds update.
  - Cleared on reset and on an accepted start; held in DONE.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package bbox_pkg holds:
  - state enum type (IDLE/SCAN/DRAIN/DONE)
  - tag struct (valid, x, y, last) for the delay line
  - address-calculation function
- Sub-module bbox_rd_pipe: parametrised RD_LAT-deep delay line for tags, with async reset clearing the valid bits.
- Counters, FSM and compare/fold logic stay in bbox_scanner.

Test Plan (memory model honours RD_LAT; base config IMG_W=4, IMG_H=3, CHANNELS=3, RD_LAT=2):
1. Single hit: word for pixel (2,1) channel 1 = 0x0010, all others 0, threshold 5 -> x_min=x_max=2, y_min=y_max=1, obj_found=1; 36 consecutive rd_en cycles; done 3 cycles after the last rd_en.
2. Empty image: all words 0, threshold 5 -> obj_found=0, x_min=3, x_max=0, y_min=2, y_max=0, done=1.
3. Threshold edge: pixel (0,0) ch2=5 and pixel (3,2) ch0=4, threshold 5 -> box (0,0)-(0,0); rerun with threshold 4 -> box (0,0)-(3,2).
4. Control: start pulsed during SCAN -> ignored, burst length unchanged; start in DONE -> done drops next cycle and bounds are cleared; rst_n low mid-SCAN -> all outputs return to reset values asynchronously.
5. Sweep RD_LAT=1 and RD_LAT=4 with IMG_W=1, IMG_H=1, CHANNELS=1, word=0xFFFF -> box (0,0)-(0,0); done RD_LAT+1 cycles after the single rd_en.
6. With BBOX_PIXEL_COUNT_EN defined: checkerboard of hits on the 4x3 image -> pixel_count=6, box (0,0)-(3,2).

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared types and helpers for the bounding-box scanner.
// The read-pipeline tag carries fixed-width coordinates; COORD_W must not exceed TAG_CW.
package bbox_pkg;

   localparam int TAG_CW = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bbox_state_e;

   typedef struct packed {
      logic              valid;
      logic [TAG_CW-1:0] x;
      logic [TAG_CW-1:0] y;
      logic              last;
   } bbox_tag_t;

   // Column-major layout: channels of a pixel are consecutive, then y, then x.
   function automatic logic [31:0] bbox_addr(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic [31:0] c,
                                             input logic [31:0] img_h,
                                             input logic [31:0] channels);
      return (x * img_h + y) * channels + c;
   endfunction

endpackage

// File: rtl/bbox_rd_pipe.sv
// RD_LAT-deep delay line that keeps each read's tag aligned with its returning data.
module bbox_rd_pipe
   import bbox_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   input  bbox_tag_t tag_in,
   output bbox_tag_t tag_out
);

   bbox_tag_t stage_q [RD_LAT];
   bbox_tag_t stage_d [RD_LAT];

   always_comb begin
      stage_d[0] = tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Reset empties the line so returns from an aborted scan are never folded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/bbox_scanner.sv
// Scans a column-major multi-channel image and reports the bounding box of threshold hits.
// Optional BBOX_PIXEL_COUNT_EN adds a pixel_count output counting hit pixels.
module bbox_scanner
   import bbox_pkg::*;
#(
   parameter int IMG_W    = 100,
   parameter int IMG_H    = 100,
   parameter int CHANNELS = 3,
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 24,
   parameter int COORD_W  = 11,
   parameter int RD_LAT   = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [DATA_W-1:0]  threshold,
   output logic               busy,
   output logic               done,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  addr,
   input  logic [DATA_W-1:0]  rddata,
   output logic               obj_found,
   output logic [COORD_W-1:0] x_min,
   output logic [COORD_W-1:0] x_max,
   output logic [COORD_W-1:0] y_min,
   output logic [COORD_W-1:0] y_max
`ifdef BBOX_PIXEL_COUNT_EN
   ,
   output logic [$clog2(IMG_W*IMG_H+1)-1:0] pixel_count
`endif
);

   localparam int CH_W = $clog2(CHANNELS + 1);
   localparam logic [COORD_W-1:0] X_MIN_RST = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] Y_MIN_RST = COORD_W'(IMG_H - 1);

   bbox_state_e        state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [CH_W-1:0]    c_q, c_d;
   logic [2:0]         drain_q, drain_d;
   logic [DATA_W-1:0]  thr_q, thr_d;
   logic               pix_hit_q, pix_hit_d;
   logic               obj_found_q, obj_found_d;
   logic [COORD_W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
   logic [COORD_W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;

   logic               last_x, last_y, last_c;
   logic               start_acc;
   logic               word_hit, pixel_hit, fold_hit;
   logic [COORD_W-1:0] tag_x, tag_y;
   bbox_tag_t          tag_in, tag_out;

   assign last_x    = (x_q == COORD_W'(IMG_W - 1));
   assign last_y    = (y_q == COORD_W'(IMG_H - 1));
   assign last_c    = (c_q == CH_W'(CHANNELS - 1));
   assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   assign busy  = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
   assign done  = (state_q == ST_DONE);
   assign rd_en = (state_q == ST_SCAN);
   assign addr  = rd_en ? ADDR_W'(bbox_addr(32'(x_q), 32'(y_q), 32'(c_q),
                                            32'(IMG_H), 32'(CHANNELS))) : '0;

   assign tag_in.valid = rd_en;
   assign tag_in.x     = TAG_CW'(x_q);
   assign tag_in.y     = TAG_CW'(y_q);
   assign tag_in.last  = last_c;

   bbox_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign tag_x     = COORD_W'(tag_out.x);
   assign tag_y     = COORD_W'(tag_out.y);
   assign word_hit  = tag_out.valid && (rddata >= thr_q);
   assign pixel_hit = pix_hit_q || word_hit;
   assign fold_hit  = tag_out.valid && tag_out.last && pixel_hit;

   // Fold returning words into the per-pixel hit, then the box on a pixel's last word.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      c_d         = c_q;
      drain_d     = drain_q;
      thr_d       = thr_q;
      pix_hit_d   = pix_hit_q;
      obj_found_d = obj_found_q;
      x_min_d     = x_min_q;
      x_max_d     = x_max_q;
      y_min_d     = y_min_q;
      y_max_d     = y_max_q;

      if (tag_out.valid) begin
         if (tag_out.last) begin
            pix_hit_d = 1'b0;
         end else begin
            pix_hit_d = pixel_hit;
         end
      end

      if (fold_hit) begin
         obj_found_d = 1'b1;
         if (tag_x < x_min_q) x_min_d = tag_x;
         if (tag_x > x_max_q) x_max_d = tag_x;
         if (tag_y < y_min_q) y_min_d = tag_y;
         if (tag_y > y_max_q) y_max_d = tag_y;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_SCAN;
               thr_d       = threshold;
               x_d         = '0;
               y_d         = '0;
               c_d         = '0;
               pix_hit_d   = 1'b0;
               obj_found_d = 1'b0;
               x_min_d     = X_MIN_RST;
               x_max_d     = '0;
               y_min_d     = Y_MIN_RST;
               y_max_d     = '0;
            end
         end
         ST_SCAN: begin
            if (!last_c) begin
               c_d = c_q + CH_W'(1);
            end else begin
               c_d = '0;
               if (!last_y) begin
                  y_d = y_q + COORD_W'(1);
               end else begin
                  y_d = '0;
                  if (!last_x) begin
                     x_d = x_q + COORD_W'(1);
                  end else begin
                     x_d     = '0;
                     drain_d = '0;
                     state_d = ST_DRAIN;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == 3'(RD_LAT - 1)) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         c_q         <= '0;
         drain_q     <= '0;
         thr_q       <= '0;
         pix_hit_q   <= 1'b0;
         obj_found_q <= 1'b0;
         x_min_q     <= X_MIN_RST;
         x_max_q     <= '0;
         y_min_q     <= Y_MIN_RST;
         y_max_q     <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         c_q         <= c_d;
         drain_q     <= drain_d;
         thr_q       <= thr_d;
         pix_hit_q   <= pix_hit_d;
         obj_found_q <= obj_found_d;
         x_min_q     <= x_min_d;
         x_max_q     <= x_max_d;
         y_min_q     <= y_min_d;
         y_max_q     <= y_max_d;
      end
   end

   assign obj_found = obj_found_q;
   assign x_min     = x_min_q;
   assign x_max     = x_max_q;
   assign y_min     = y_min_q;
   assign y_max     = y_max_q;

`ifdef BBOX_PIXEL_COUNT_EN
   localparam int PC_W = $clog2(IMG_W*IMG_H+1);

   logic [PC_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (start_acc) begin
         count_d = '0;
      end else if (fold_hit) begin
         count_d = count_q + PC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign pixel_count = count_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_bbox_scanner.sv
// Directed bench for bbox_scanner: a 4x3x3 image at RD_LAT=2 plus two 1x1 images at RD_LAT=1 and 4.
// Building with BBOX_PIXEL_COUNT_EN also checks pixel_count.
module tb_bbox_scanner;

   localparam int AW = 24;
   localparam int CW = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   int            checks = 0;
   int            failures = 0;

   // Base 4x3x3 instance with a two-cycle memory model
   logic          start;
   logic [15:0]   threshold;
   logic          busy, done, rd_en, obj_found;
   logic [AW-1:0] addr;
   logic [15:0]   rddata;
   logic [CW-1:0] x_min, x_max, y_min, y_max;
   logic [15:0]   mem [36];
   logic [15:0]   rd_pipe [2];
`ifdef BBOX_PIXEL_COUNT_EN
   logic [3:0]    pixel_count;
`endif

   always @(posedge clk) begin
      rd_pipe[0] <= (rd_en && addr < AW'(36)) ? mem[addr[5:0]] : 16'h0;
      rd_pipe[1] <= rd_pipe[0];
   end
   assign rddata = rd_pipe[1];

   bbox_scanner #(.IMG_W(4), .IMG_H(3), .CHANNELS(3), .DATA_W(16), .ADDR_W(AW),
                  .COORD_W(CW), .RD_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .threshold(threshold),
      .busy(busy), .done(done), .rd_en(rd_en), .addr(addr), .rddata(rddata),
      .obj_found(obj_found), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max)
`ifdef BBOX_PIXEL_COUNT_EN
      , .pixel_count(pixel_count)
`endif
   );

   // Two 1x1x1 instances sharing one stimulus, at RD_LAT 1 and 4
   logic          t_start;
   logic [15:0]   t_threshold, tiny_word;
   logic          t1_busy, t1_done, t1_rd_en, t1_obj;
   logic          t4_busy, t4_done, t4_rd_en, t4_obj;
   logic [AW-1:0] t1_addr, t4_addr;
   logic [15:0]   t1_rdata, t4_rdata;
   logic [15:0]   t4_pipe [4];
   logic [CW-1:0] t1_xmin, t1_xmax, t1_ymin, t1_ymax;
   logic [CW-1:0] t4_xmin, t4_xmax, t4_ymin, t4_ymax;
`ifdef BBOX_PIXEL_COUNT_EN
   logic          t1_pc, t4_pc;
`endif

   always @(posedge clk) begin
      t1_rdata   <= (t1_rd_en && t1_addr == '0) ? tiny_word : 16'h0;
      t4_pipe[0] <= (t4_rd_en && t4_addr == '0) ? tiny_word : 16'h0;
      for (int i = 1; i < 4; i++) t4_pipe[i] <= t4_pipe[i-1];
   end
   assign t4_rdata = t4_pipe[3];

   bbox_scanner #(.IMG_W(1), .IMG_H(1), .CHANNELS(1), .DATA_W(16), .ADDR_W(AW),
                  .COORD_W(CW), .RD_LAT(1)) dut_t1 (
      .clk(clk), .rst_n(rst_n), .start(t_start), .threshold(t_threshold),
      .busy(t1_busy), .done(t1_done), .rd_en(t1_rd_en), .addr(t1_addr), .rddata(t1_rdata),
      .obj_found(t1_obj), .x_min(t1_xmin), .x_max(t1_xmax), .y_min(t1_ymin), .y_max(t1_ymax)
`ifdef BBOX_PIXEL_COUNT_EN
      , .pixel_count(t1_pc)
`endif
   );

   bbox_scanner #(.IMG_W(1), .IMG_H(1), .CHANNELS(1), .DATA_W(16), .ADDR_W(AW),
                  .COORD_W(CW), .RD_LAT(4)) dut_t4 (
      .clk(clk), .rst_n(rst_n), .start(t_start), .threshold(t_threshold),
      .busy(t4_busy), .done(t4_done), .rd_en(t4_rd_en), .addr(t4_addr), .rddata(t4_rdata),
      .obj_found(t4_obj), .x_min(t4_xmin), .x_max(t4_xmax), .y_min(t4_ymin), .y_max(t4_ymax)
`ifdef BBOX_PIXEL_COUNT_EN
      , .pixel_count(t4_pc)
`endif
   );

   int burst, gap;
   bit contig, timed_out;

   task automatic clear_mem();
      for (int i = 0; i < 36; i++) mem[i] = 16'h0;
   endtask

   // Start a scan, scramble the threshold input afterwards, and measure the burst and done latency.
   task automatic run_scan(input logic [15:0] thr, input int pulse_at);
      int cyc, first, last;
      @(negedge clk);
      threshold = thr;
      start     = 1'b1;
      burst = 0; gap = -1; first = -1; last = -1; timed_out = 1'b1;
      for (cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         threshold = 16'h0;
         start     = (cyc == pulse_at);
         if (rd_en) begin
            burst++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (done) begin
            gap       = cyc - last;
            timed_out = 1'b0;
            break;
         end
      end
      start  = 1'b0;
      contig = (last - first + 1 == burst);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; threshold = 16'h0;
      t_start = 1'b0; t_threshold = 16'h0; tiny_word = 16'h0;
      clear_mem();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, rd_en, addr, obj_found, x_min, x_max, y_min, y_max} !==
          {1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 11'd3, 11'd0, 11'd2, 11'd0}) begin
         failures++;
         $display("[TB] FAIL reset_state got busy=%b done=%b rd_en=%b addr=%0d obj=%b box=%0d,%0d,%0d,%0d expected 0 0 0 0 0 box=3,0,2,0",
                  busy, done, rd_en, addr, obj_found, x_min, x_max, y_min, y_max);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, rd_en} !== 3'b000) begin
         failures++;
         $display("[TB] FAIL idle_after_reset got busy/done/rd_en=%b expected 000", {busy, done, rd_en});
      end
   endtask

   task automatic test_single_hit();
      clear_mem();
      mem[22] = 16'h0010;
      run_scan(16'd5, 0);
      checks++;
      if (timed_out || burst != 36 || !contig) begin
         failures++;
         $display("[TB] FAIL single_burst got burst=%0d contig=%b timeout=%b expected 36 contiguous", burst, contig, timed_out);
      end
      checks++;
      if (gap != 3) begin
         failures++;
         $display("[TB] FAIL single_done_latency got %0d expected 3", gap);
      end
      checks++;
      if ({obj_found, x_min, x_max, y_min, y_max} !== {1'b1, 11'd2, 11'd2, 11'd1, 11'd1}) begin
         failures++;
         $display("[TB] FAIL single_box got obj=%b box=%0d,%0d,%0d,%0d expected 1 box=2,2,1,1",
                  obj_found, x_min, x_max, y_min, y_max);
      end
   endtask

   task automatic test_empty();
      clear_mem();
      run_scan(16'd5, 0);
      checks++;
      if ({timed_out, done, obj_found, x_min, x_max, y_min, y_max} !==
          {1'b0, 1'b1, 1'b0, 11'd3, 11'd0, 11'd2, 11'd0}) begin
         failures++;
         $display("[TB] FAIL empty_box got timeout=%b done=%b obj=%b box=%0d,%0d,%0d,%0d expected 0 1 0 box=3,0,2,0",
                  timed_out, done, obj_found, x_min, x_max, y_min, y_max);
      end
   endtask

   task automatic test_threshold_edge();
      clear_mem();
      mem[2]  = 16'd5;
      mem[33] = 16'd4;
      run_scan(16'd5, 0);
      checks++;
      if ({timed_out, obj_found, x_min, x_max, y_min, y_max} !== {1'b0, 1'b1, 11'd0, 11'd0, 11'd0, 11'd0}) begin
         failures++;
         $display("[TB] FAIL edge_thr5 got timeout=%b obj=%b box=%0d,%0d,%0d,%0d expected 0 1 box=0,0,0,0",
                  timed_out, obj_found, x_min, x_max, y_min, y_max);
      end
      run_scan(16'd4, 0);
      checks++;
      if ({timed_out, obj_found, x_min, x_max, y_min, y_max} !== {1'b0, 1'b1, 11'd0, 11'd3, 11'd0, 11'd2}) begin
         failures++;
         $display("[TB] FAIL edge_thr4 got timeout=%b obj=%b box=%0d,%0d,%0d,%0d expected 0 1 box=0,3,0,2",
                  timed_out, obj_found, x_min, x_max, y_min, y_max);
      end
   endtask

   task automatic test_control();
      int n;
      // Memory still holds the threshold-edge image: hits at (0,0) and, at threshold 4, (3,2).
      run_scan(16'd4, 10);
      checks++;
      if (timed_out || burst != 36 || !contig || gap != 3) begin
         failures++;
         $display("[TB] FAIL start_in_scan got burst=%0d contig=%b gap=%0d timeout=%b expected 36 1 3 0",
                  burst, contig, gap, timed_out);
      end
      checks++;
      if ({obj_found, x_min, x_max, y_min, y_max} !== {1'b1, 11'd0, 11'd3, 11'd0, 11'd2}) begin
         failures++;
         $display("[TB] FAIL start_in_scan_box got obj=%b box=%0d,%0d,%0d,%0d expected 1 box=0,3,0,2",
                  obj_found, x_min, x_max, y_min, y_max);
      end
      // Restart straight from DONE.
      @(negedge clk);
      threshold = 16'd4;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({done, busy, obj_found, x_min, x_max, y_min, y_max} !==
          {1'b0, 1'b1, 1'b0, 11'd3, 11'd0, 11'd2, 11'd0}) begin
         failures++;
         $display("[TB] FAIL restart_from_done got done=%b busy=%b obj=%b box=%0d,%0d,%0d,%0d expected 0 1 0 box=3,0,2,0",
                  done, busy, obj_found, x_min, x_max, y_min, y_max);
      end
`ifdef BBOX_PIXEL_COUNT_EN
      checks++;
      if (pixel_count !== 4'd0) begin
         failures++;
         $display("[TB] FAIL restart_count_clear got %0d expected 0", pixel_count);
      end
`endif
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("[TB] FAIL restart_completes got done=0 after %0d cycles expected 1", n);
      end
      // Abort a scan once pixel (0,0) has already been folded in.
      run_scan_abort();
   endtask

   task automatic run_scan_abort();
      @(negedge clk);
      threshold = 16'd4;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      checks++;
      if ({rd_en, obj_found} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL midscan_precondition got rd_en/obj=%b expected 11", {rd_en, obj_found});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, rd_en, addr, obj_found, x_min, x_max, y_min, y_max} !==
          {1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 11'd3, 11'd0, 11'd2, 11'd0}) begin
         failures++;
         $display("[TB] FAIL midscan_reset got busy=%b done=%b rd_en=%b addr=%0d obj=%b box=%0d,%0d,%0d,%0d expected 0 0 0 0 0 box=3,0,2,0",
                  busy, done, rd_en, addr, obj_found, x_min, x_max, y_min, y_max);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, rd_en, obj_found} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL after_reset_idle got busy/done/rd_en/obj=%b expected 0000", {busy, done, rd_en, obj_found});
      end
   endtask

   task automatic test_back_to_back();
      run_scan(16'd4, 0);
      checks++;
      if ({timed_out, burst == 36, obj_found, x_min, x_max, y_min, y_max} !==
          {1'b0, 1'b1, 1'b1, 11'd0, 11'd3, 11'd0, 11'd2}) begin
         failures++;
         $display("[TB] FAIL rescan_after_reset got timeout=%b burst=%0d obj=%b box=%0d,%0d,%0d,%0d expected 0 36 1 box=0,3,0,2",
                  timed_out, burst, obj_found, x_min, x_max, y_min, y_max);
      end
   endtask

   task automatic test_checkerboard();
      clear_mem();
      for (int x = 0; x < 4; x++) begin
         for (int y = 0; y < 3; y++) begin
            if ((x + y) % 2 == 0) mem[(x*3 + y)*3 + (x % 3)] = 16'h0100;
            else                  mem[(x*3 + y)*3 + (y % 3)] = 16'h007F;
         end
      end
      run_scan(16'h0080, 0);
      checks++;
      if ({timed_out, obj_found, x_min, x_max, y_min, y_max} !== {1'b0, 1'b1, 11'd0, 11'd3, 11'd0, 11'd2}) begin
         failures++;
         $display("[TB] FAIL checker_box got timeout=%b obj=%b box=%0d,%0d,%0d,%0d expected 0 1 box=0,3,0,2",
                  timed_out, obj_found, x_min, x_max, y_min, y_max);
      end
`ifdef BBOX_PIXEL_COUNT_EN
      checks++;
      if (pixel_count !== 4'd6) begin
         failures++;
         $display("[TB] FAIL checker_count got %0d expected 6", pixel_count);
      end
`endif
   endtask

   task automatic test_rd_lat_sweep();
      int b1, b4, l1, l4, d1, d4;
      for (int pass = 0; pass < 2; pass++) begin
         tiny_word = (pass == 0) ? 16'hFFFF : 16'hFFFE;
         @(negedge clk);
         t_threshold = 16'hFFFF;
         t_start     = 1'b1;
         b1 = 0; b4 = 0; l1 = -1; l4 = -1; d1 = -1; d4 = -1;
         for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            t_start = 1'b0;
            if (t1_rd_en) begin b1++; l1 = cyc; end
            if (t4_rd_en) begin b4++; l4 = cyc; end
            if (t1_done && d1 < 0) d1 = cyc;
            if (t4_done && d4 < 0) d4 = cyc;
         end
         checks++;
         if (b1 != 1 || d1 - l1 != 2) begin
            failures++;
            $display("[TB] FAIL lat1_timing pass%0d got bursts=%0d done_gap=%0d expected 1 2", pass, b1, d1 - l1);
         end
         checks++;
         if (b4 != 1 || d4 - l4 != 5) begin
            failures++;
            $display("[TB] FAIL lat4_timing pass%0d got bursts=%0d done_gap=%0d expected 1 5", pass, b4, d4 - l4);
         end
         checks++;
         if ({t1_obj, t1_xmin, t1_xmax, t1_ymin, t1_ymax, t4_obj, t4_xmin, t4_xmax, t4_ymin, t4_ymax} !==
             {(pass == 0), 44'h0, (pass == 0), 44'h0}) begin
            failures++;
            $display("[TB] FAIL tiny_box pass%0d got obj1=%b obj4=%b box1=%0d,%0d,%0d,%0d box4=%0d,%0d,%0d,%0d expected obj=%0d boxes 0",
                     pass, t1_obj, t4_obj, t1_xmin, t1_xmax, t1_ymin, t1_ymax,
                     t4_xmin, t4_xmax, t4_ymin, t4_ymax, (pass == 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_empty();
      test_threshold_edge();
      test_control();
      test_back_to_back();
      test_checkerboard();
      test_rd_lat_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
